// File: rtl/block_scheduler.sv
// Job dispatcher: walks an R x C grid of block index pairs row-major and hands each
// pair to an idle processing unit chosen round-robin, tracking completions and status.
module block_scheduler #(
   parameter int unsigned NUM_PU       = 4,
   parameter int unsigned INDEX_WIDTH  = 8,
   parameter int unsigned STATUS_WIDTH = 32
) (
   input  logic                       in_clk,
   input  logic                       in_reset,
   input  logic                       in_start,
   input  logic [INDEX_WIDTH-1:0]     in_row_blocks,
   input  logic [INDEX_WIDTH-1:0]     in_col_blocks,
   input  logic [NUM_PU-1:0]          in_req,
   input  logic [NUM_PU-1:0]          in_ack,
   input  logic [NUM_PU-1:0]          in_done,
   output logic [INDEX_WIDTH-1:0]     out_row_index,
   output logic [INDEX_WIDTH-1:0]     out_col_index,
   output logic [NUM_PU-1:0]          out_index_valid,
   output logic                       out_busy,
   output logic                       out_finish,
   output logic                       out_status_we,
   output logic [STATUS_WIDTH-1:0]    out_status,
   output logic [2*INDEX_WIDTH-1:0]   out_jobs_done
);

   localparam int unsigned PTR_W = (NUM_PU > 1) ? $clog2(NUM_PU) : 1;
   localparam int unsigned CNT_W = 2 * INDEX_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DISPATCH,
      S_WAIT_ACK,
      S_DRAIN,
      S_FINISH
   } state_t;

   state_t                 state;
   logic [PTR_W-1:0]       rr_ptr;
   logic [PTR_W-1:0]       grant;
   logic [NUM_PU-1:0]      pu_busy;
   logic [INDEX_WIDTH-1:0] row_blocks;
   logic [INDEX_WIDTH-1:0] col_blocks;
   logic [INDEX_WIDTH-1:0] row_idx;
   logic [INDEX_WIDTH-1:0] col_idx;
   logic [CNT_W-1:0]       total;
   logic                   error;

   logic [NUM_PU-1:0]      cand;
   logic                   cand_any;
   logic [PTR_W-1:0]       cand_idx;
   logic [PTR_W-1:0]       pos;
   logic [NUM_PU-1:0]      done_hit;
   logic [NUM_PU-1:0]      done_stray;
   logic [CNT_W-1:0]       done_cnt;
   logic                   acked;
   logic [NUM_PU-1:0]      ack_set;
   logic [PTR_W-1:0]       ptr_next;
   logic                   last_col;
   logic                   last_row;

   function automatic logic [STATUS_WIDTH-1:0] pack_status(input logic busy, input logic done,
                                                           input logic err,
                                                           input logic [CNT_W-1:0] jobs);
      logic [15:0] jobs16;
      jobs16 = 16'(jobs);
      return STATUS_WIDTH'({jobs16, 13'b0, err, done, busy});
   endfunction

   // Round-robin pick, completion accounting and grid-walk helpers.
   always_comb begin
      cand     = in_req & ~pu_busy;
      cand_any = 1'b0;
      cand_idx = '0;
      pos      = '0;
      for (int i = 0; i < int'(NUM_PU); i++) begin
         pos = PTR_W'((int'(rr_ptr) + i) % int'(NUM_PU));
         if (!cand_any && cand[pos]) begin
            cand_any = 1'b1;
            cand_idx = pos;
         end
      end

      done_hit   = in_done & pu_busy;
      done_stray = in_done & ~pu_busy;
      done_cnt   = '0;
      for (int k = 0; k < int'(NUM_PU); k++) begin
         done_cnt = done_cnt + CNT_W'(done_hit[k]);
      end

      acked    = in_ack[grant];
      ack_set  = (state == S_WAIT_ACK && acked) ? (NUM_PU'(1) << grant) : '0;
      ptr_next = (grant == PTR_W'(NUM_PU - 1)) ? '0 : grant + PTR_W'(1);
      last_col = (col_idx == col_blocks - INDEX_WIDTH'(1));
      last_row = (row_idx == row_blocks - INDEX_WIDTH'(1));
   end

   always_ff @(posedge in_clk) begin
      if (in_reset) begin
         state           <= S_IDLE;
         rr_ptr          <= '0;
         grant           <= '0;
         pu_busy         <= '0;
         row_blocks      <= '0;
         col_blocks      <= '0;
         row_idx         <= '0;
         col_idx         <= '0;
         total           <= '0;
         error           <= 1'b0;
         out_row_index   <= '0;
         out_col_index   <= '0;
         out_index_valid <= '0;
         out_busy        <= 1'b0;
         out_finish      <= 1'b0;
         out_status_we   <= 1'b0;
         out_status      <= '0;
         out_jobs_done   <= '0;
      end else begin
         out_finish    <= 1'b0;
         out_status_we <= 1'b0;
         // A done from the unit being acked this edge targets no job: busy still sets.
         pu_busy       <= (pu_busy & ~done_hit) | ack_set;
         out_jobs_done <= out_jobs_done + done_cnt;
         error         <= error | (|done_stray);

         case (state)
            S_IDLE: begin
               if (in_start) begin
                  row_blocks    <= in_row_blocks;
                  col_blocks    <= in_col_blocks;
                  total         <= CNT_W'(in_row_blocks) * CNT_W'(in_col_blocks);
                  row_idx       <= '0;
                  col_idx       <= '0;
                  out_jobs_done <= '0;
                  error         <= 1'b0;
                  out_busy      <= 1'b1;
                  out_status_we <= 1'b1;
                  out_status    <= pack_status(1'b1, 1'b0, 1'b0, '0);
                  state         <= (in_row_blocks == '0 || in_col_blocks == '0) ? S_FINISH
                                                                                 : S_DISPATCH;
               end
            end

            S_DISPATCH: begin
               if (cand_any) begin
                  grant           <= cand_idx;
                  out_index_valid <= NUM_PU'(1) << cand_idx;
                  out_row_index   <= row_idx;
                  out_col_index   <= col_idx;
                  state           <= S_WAIT_ACK;
               end
            end

            S_WAIT_ACK: begin
               if (acked) begin
                  out_index_valid <= '0;
                  rr_ptr          <= ptr_next;
                  if (last_col) begin
                     col_idx <= '0;
                     row_idx <= row_idx + INDEX_WIDTH'(1);
                  end else begin
                     col_idx <= col_idx + INDEX_WIDTH'(1);
                  end
                  state <= (last_row && last_col) ? S_DRAIN : S_DISPATCH;
               end
            end

            S_DRAIN: begin
               if (out_jobs_done == total) begin
                  state <= S_FINISH;
               end
            end

            S_FINISH: begin
               out_finish    <= 1'b1;
               out_status_we <= 1'b1;
               out_status    <= pack_status(1'b0, 1'b1, error, out_jobs_done);
               out_busy      <= 1'b0;
               state         <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_block_scheduler.sv
// Directed bench for block_scheduler: transaction-level model compared every cycle,
// plus literal expectations for offer order, status words and reset behaviour.
module tb_block_scheduler;

   localparam int unsigned NPU = 4;
   localparam int unsigned IW  = 8;
   localparam int unsigned SW  = 32;

   logic          clk = 1'b0;
   logic          in_reset = 1'b0, in_start = 1'b0;
   logic [IW-1:0] in_row_blocks = '0, in_col_blocks = '0;
   logic [NPU-1:0] in_req = '0, in_ack = '0, in_done = '0;
   logic [IW-1:0] out_row_index, out_col_index;
   logic [NPU-1:0] out_index_valid;
   logic          out_busy, out_finish, out_status_we;
   logic [SW-1:0] out_status;
   logic [2*IW-1:0] out_jobs_done;

   always #5 clk = ~clk;

   block_scheduler #(.NUM_PU(NPU), .INDEX_WIDTH(IW), .STATUS_WIDTH(SW)) dut (
      .in_clk(clk), .in_reset(in_reset), .in_start(in_start),
      .in_row_blocks(in_row_blocks), .in_col_blocks(in_col_blocks),
      .in_req(in_req), .in_ack(in_ack), .in_done(in_done),
      .out_row_index(out_row_index), .out_col_index(out_col_index),
      .out_index_valid(out_index_valid), .out_busy(out_busy), .out_finish(out_finish),
      .out_status_we(out_status_we), .out_status(out_status), .out_jobs_done(out_jobs_done)
   );

   int n_vec = 0, n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Model: run phases, job count n mapped to (n / C, n % C), outstanding-unit mask.
   logic [NPU-1:0] m_pbusy = '0, e_valid = '0, t_old_pb, t_cand;
   int  m_ptr = 0, m_g = 0, m_n = 0, m_total = 0, m_R = 0, m_C = 1, m_jobs = 0;
   bit  m_err = 0, ph_disp = 0, ph_wait = 0, ph_drain = 0, ph_fin = 0;
   int  e_row = 0, e_col = 0, t_old_jobs, t_u;
   bit  e_busy = 0, e_finish = 0, e_we = 0, t_old_err, t_found, chk_on = 0;
   logic [SW-1:0] e_status = '0;

   initial begin : model
      forever begin
         @(posedge clk);
         if (in_reset) begin
            m_pbusy = '0; m_ptr = 0; m_g = 0; m_n = 0; m_total = 0; m_jobs = 0; m_err = 0;
            ph_disp = 0; ph_wait = 0; ph_drain = 0; ph_fin = 0;
            e_valid = '0; e_row = 0; e_col = 0; e_busy = 0; e_finish = 0; e_we = 0;
            e_status = '0;
         end else begin
            t_old_jobs = m_jobs; t_old_err = m_err; t_old_pb = m_pbusy;
            e_finish = 0; e_we = 0;
            for (int k = 0; k < int'(NPU); k++) begin
               if (in_done[k]) begin
                  if (t_old_pb[k]) begin m_pbusy[k] = 1'b0; m_jobs++; end
                  else m_err = 1;
               end
            end
            if (ph_fin) begin
               e_finish = 1; e_we = 1; e_busy = 0; ph_fin = 0;
               e_status = 32'({16'(t_old_jobs), 13'b0, t_old_err, 1'b1, 1'b0});
            end else if (!e_busy) begin
               if (in_start) begin
                  m_R = int'(in_row_blocks); m_C = int'(in_col_blocks); m_total = m_R * m_C;
                  m_jobs = 0; m_err = 0; m_n = 0;
                  e_busy = 1; e_we = 1; e_status = 32'h1;
                  if (m_total == 0) ph_fin = 1; else ph_disp = 1;
               end
            end else if (ph_drain) begin
               if (t_old_jobs == m_total) begin ph_drain = 0; ph_fin = 1; end
            end else if (ph_disp) begin
               t_cand = in_req & ~t_old_pb;
               t_found = 0;
               for (int i = 0; i < int'(NPU); i++) begin
                  t_u = (m_ptr + i) % int'(NPU);
                  if (!t_found && t_cand[t_u]) begin t_found = 1; m_g = t_u; end
               end
               if (t_found) begin
                  e_valid = NPU'(1 << m_g);
                  e_row = m_n / m_C; e_col = m_n % m_C;
                  ph_disp = 0; ph_wait = 1;
               end
            end else if (ph_wait) begin
               if (in_ack[m_g]) begin
                  e_valid = '0; m_pbusy[m_g] = 1'b1; m_ptr = (m_g + 1) % int'(NPU);
                  m_n++; ph_wait = 0;
                  if (m_n == m_total) ph_drain = 1; else ph_disp = 1;
               end
            end
         end
         @(negedge clk);
         if (chk_on) begin
            chk("valid", 64'(out_index_valid), 64'(e_valid));
            if (e_valid != '0) begin
               chk("row_index", 64'(out_row_index), 64'(e_row));
               chk("col_index", 64'(out_col_index), 64'(e_col));
            end
            chk("busy", 64'(out_busy), 64'(e_busy));
            chk("finish", 64'(out_finish), 64'(e_finish));
            chk("status_we", 64'(out_status_we), 64'(e_we));
            chk("status", 64'(out_status), 64'(e_status));
            chk("jobs_done", 64'(out_jobs_done), 64'(16'(m_jobs)));
         end
      end
   end

   // Processing-unit responders and offer log.
   bit  ack_en = 1, auto_done = 1;
   logic [NPU-1:0] req_mask = '1, prev_valid = '0;
   int  tmr[NPU];
   int  cyc = 0, fin_cnt = 0, off_cnt = 0;
   int  off_unit[16], off_row[16], off_col[16];

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      in_start = 1'b0;
      in_reset = 1'b0;
      if (out_finish) fin_cnt++;
      if (out_index_valid != '0 && prev_valid == '0 && off_cnt < 16) begin
         for (int k = 0; k < int'(NPU); k++) if (out_index_valid[k]) off_unit[off_cnt] = k;
         off_row[off_cnt] = int'(out_row_index);
         off_col[off_cnt] = int'(out_col_index);
         off_cnt++;
      end
      prev_valid = out_index_valid;
      in_done = '0;
      for (int k = 0; k < int'(NPU); k++) begin
         if (tmr[k] > 0) begin
            tmr[k]--;
            if (tmr[k] == 0) in_done[k] = 1'b1;
         end
      end
      in_ack = ack_en ? out_index_valid : '0;
      for (int k = 0; k < int'(NPU); k++) if (in_ack[k] && auto_done) tmr[k] = 3;
      in_req = req_mask;
   endtask

   task automatic start_run(input int r, input int c);
      in_row_blocks = IW'(r);
      in_col_blocks = IW'(c);
      in_start = 1'b1;
      off_cnt = 0;
      step();
   endtask

   task automatic wait_finish(input int budget);
      int f0;
      f0 = fin_cnt;
      for (int i = 0; i < budget && fin_cnt == f0; i++) step();
      chk("finish_seen", 64'(fin_cnt != f0), 64'(1));
   endtask

   int exp_u[6] = '{0, 1, 2, 3, 0, 1};
   int exp_r[6] = '{0, 0, 0, 1, 1, 1};
   int exp_c[6] = '{0, 1, 2, 0, 1, 2};
   int fin0;

   initial begin : stim
      for (int k = 0; k < int'(NPU); k++) tmr[k] = 0;
      in_reset = 1'b1; step();
      in_reset = 1'b1; step();
      chk_on = 1;
      chk("rst_busy", 64'(out_busy), 64'(0));
      chk("rst_valid", 64'(out_index_valid), 64'(0));
      chk("rst_jobs", 64'(out_jobs_done), 64'(0));
      chk("rst_status", 64'(out_status), 64'(0));
      step();

      // 2x3 grid, all units requesting
      fin0 = fin_cnt;
      start_run(2, 3);
      wait_finish(200);
      chk("t1_status", 64'(out_status), 64'h0006_0002);
      repeat (3) step();
      chk("t1_finish_count", 64'(fin_cnt - fin0), 64'(1));
      chk("t1_offers", 64'(off_cnt), 64'(6));
      for (int i = 0; i < 6; i++) begin
         chk("t1_unit", 64'(off_unit[i]), 64'(exp_u[i]));
         chk("t1_row", 64'(off_row[i]), 64'(exp_r[i]));
         chk("t1_col", 64'(off_col[i]), 64'(exp_c[i]));
      end

      // zero-row grid finishes immediately
      start_run(0, 5);
      chk("t2_we", 64'(out_status_we), 64'(1));
      chk("t2_busy_status", 64'(out_status), 64'h1);
      step();
      chk("t2_finish", 64'(out_finish), 64'(1));
      chk("t2_status", 64'(out_status), 64'h0000_0002);
      repeat (2) step();
      chk("t2_offers", 64'(off_cnt), 64'(0));

      // only unit 2 requesting
      req_mask = 4'b0100;
      start_run(1, 3);
      wait_finish(300);
      chk("t3_offers", 64'(off_cnt), 64'(3));
      for (int i = 0; i < 3; i++) chk("t3_unit", 64'(off_unit[i]), 64'(2));
      chk("t3_jobs", 64'(out_jobs_done), 64'(3));
      req_mask = '1;
      step();

      // stray done sets sticky error, cleared by next start
      start_run(1, 1);
      in_done = in_done | 4'b0010;
      step();
      wait_finish(100);
      chk("t4_status_err", 64'(out_status), 64'h0001_0006);
      step();
      start_run(1, 1);
      chk("t4_err_cleared", 64'(out_status), 64'h1);
      wait_finish(100);
      chk("t4_status_clean", 64'(out_status), 64'h0001_0002);
      step();

      // simultaneous dones and ignored mid-run start
      auto_done = 0;
      start_run(1, 4);
      repeat (3) step();
      in_row_blocks = 8'd9; in_col_blocks = 8'd9; in_start = 1'b1;
      step();
      in_row_blocks = 8'd1; in_col_blocks = 8'd4;
      for (int i = 0; i < 60 && off_cnt < 4; i++) step();
      repeat (3) step();
      chk("t5_jobs_before", 64'(out_jobs_done), 64'(0));
      in_done = 4'b1001;
      step();
      chk("t5_jobs_two", 64'(out_jobs_done), 64'(2));
      in_done = 4'b0110;
      step();
      wait_finish(50);
      chk("t5_status", 64'(out_status), 64'h0004_0002);
      chk("t5_offers", 64'(off_cnt), 64'(4));
      auto_done = 1;
      step();

      // reset while waiting for an ack, then a clean run
      ack_en = 0;
      start_run(2, 2);
      for (int i = 0; i < 20 && out_index_valid == '0; i++) step();
      chk("t6_offer_seen", 64'(out_index_valid != '0), 64'(1));
      in_reset = 1'b1;
      step();
      chk("t6_valid", 64'(out_index_valid), 64'(0));
      chk("t6_busy", 64'(out_busy), 64'(0));
      chk("t6_jobs", 64'(out_jobs_done), 64'(0));
      ack_en = 1;
      step();
      start_run(1, 2);
      wait_finish(100);
      chk("t6_status", 64'(out_status), 64'h0002_0002);
      chk("t6_offers", 64'(off_cnt), 64'(2));

      repeat (2) step();
      chk_on = 0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got no end of stimulus, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
